// File: rtl/sccb_slave_regs.sv
// SCCB/I2C responder with a byte-wide register bank, 16-bit auto-incrementing pointer.
// Optional input deglitching is enabled by defining SCCB_SLAVE_GLITCH_FILTER_EN.
module sccb_slave_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h3C,
  parameter int unsigned MEM_AW   = 8,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_stb,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StAckDev, StRegHi, StAckHi, StRegLo, StAckLo,
    StWrByte, StAckWr, StRdByte, StRdAck, StWaitStop
  } state_e;

  // Synchronisers reset to the idle-bus level so reset release creates no events.
  logic [1:0] scl_sync_q, sda_sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

  logic scl_f, sda_f;
`ifdef SCCB_SLAVE_GLITCH_FILTER_EN
  localparam int unsigned FCW = $clog2(FILT_LEN + 1);
  logic [1:0]          filt_q;
  logic [1:0][FCW-1:0] fcnt_q;
  logic [1:0]          filt_raw;
  assign filt_raw = {scl_sync_q[1], sda_sync_q[1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 2'b11;
      fcnt_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (filt_raw[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
          filt_q[i] <= filt_raw[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end
  assign scl_f = filt_q[1];
  assign sda_f = filt_q[0];
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  logic scl_p_q, sda_p_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_f & ~scl_p_q;
  assign scl_fall = ~scl_f & scl_p_q;
  // SCL must be high in both samples, so a simultaneous SCL/SDA change is plain data.
  assign start_ev = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop_ev  = scl_f & scl_p_q & ~sda_p_q & sda_f;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] ptr_q, ptr_d;
  logic        ack_drv_q, ack_drv_d;
  logic        rd_q, rd_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        wr_stb_q, wr_stb_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        bank_we;

  logic [7:0]  bank_q [2**MEM_AW];
  logic [15:0] ptr_inc;
  logic [7:0]  byte_in, rd_cur, rd_nxt;
  assign ptr_inc = ptr_q + 16'd1;
  assign byte_in = {shift_q[6:0], sda_f};
  assign rd_cur  = bank_q[ptr_q[MEM_AW-1:0]];
  assign rd_nxt  = bank_q[ptr_inc[MEM_AW-1:0]];

  always_ff @(posedge clk) begin
    if (bank_we) bank_q[ptr_q[MEM_AW-1:0]] <= byte_in;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    ack_drv_d = ack_drv_q;
    rd_d      = rd_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    bank_we   = 1'b0;
    if (start_ev) begin
      state_d  = StDevAddr;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_ev) begin
      state_d  = StIdle;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StDevAddr, StRegHi, StRegLo, StWrByte: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ack_drv_d = 1'b0;
              case (state_q)
                StDevAddr: begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    rd_d    = byte_in[0];
                    state_d = StAckDev;
                  end else begin
                    state_d = StWaitStop;
                  end
                end
                StRegHi: begin
                  ptr_d[15:8] = byte_in;
                  state_d     = StAckHi;
                end
                StRegLo: begin
                  ptr_d[7:0] = byte_in;
                  state_d    = StAckLo;
                end
                default: begin
                  wr_stb_d  = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = byte_in;
                  bank_we   = 1'b1;
                  ptr_d     = ptr_inc;
                  state_d   = StAckWr;
                end
              endcase
            end
          end
        end
        StAckDev, StAckHi, StAckLo, StAckWr: begin
          // First fall after bit 0 starts the ACK, the second one ends it.
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_oe_d  = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              case (state_q)
                StAckDev: begin
                  if (rd_q) begin
                    shift_d  = rd_cur;
                    sda_oe_d = ~rd_cur[7];
                    state_d  = StRdByte;
                  end else begin
                    state_d = StRegHi;
                  end
                end
                StAckHi: state_d = StRegLo;
                default: state_d = StWrByte;
              endcase
            end
          end
        end
        StRdByte: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = StRdAck;
          end else if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
          end
        end
        StRdAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_f) begin
              ptr_d   = ptr_inc;
              shift_d = rd_nxt;
              cnt_d   = '0;
              state_d = StRdByte;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StWaitStop: sda_oe_d = 1'b0;
        default:    state_d  = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      ack_drv_q <= 1'b0;
      rd_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      ack_drv_q <= ack_drv_d;
      rd_q      <= rd_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_sccb_slave_regs.sv
// Bit-level SCCB master driving sccb_slave_regs, checked against a transaction-level bank model.
module tb_sccb_slave_regs;

  localparam int unsigned QCLK = 8;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst;
  logic        m_scl, m_sda;
  logic        scl_w, sda_w;
  logic        sda_oe, wr_stb, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  assign scl_w = m_scl;
  assign sda_w = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  sccb_slave_regs dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_w),
    .sda_i   (sda_w),
    .sda_oe  (sda_oe),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: bank contents, pointer, expected write strobes.
  logic [7:0]  m_mem [256];
  logic [15:0] m_ptr = 16'h0000;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [7:0]  tx_buf [16];
  int          oe_cnt = 0;

  always @(negedge clk) begin
    if (!rst && wr_stb) obs_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
  end

  task automatic wait_q(input int n);
    repeat (n * QCLK) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    m_sda = 1'b1; wait_q(2);
  endtask

  task automatic put_bit(input logic b);
    m_sda = b;    wait_q(1);
    m_scl = 1'b1; wait_q(2);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    b = sda_w;    wait_q(1);
    m_scl = 1'b0; wait_q(1);
  endtask

  task automatic put_byte(input logic [7:0] v, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(b);
    acked = ~b;
  endtask

  task automatic get_byte(output logic [7:0] v, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(~master_ack);
  endtask

  task automatic check_wr(input string tag);
    check_val({tag, "_nstb"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_val($sformatf("%s_stb%0d", tag, i), obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
  endtask

  // Write transaction: tx_buf[0..n-1] after the address byte; first two bytes set the pointer.
  task automatic txn_write(input string tag, input logic [6:0] dev, input int n, input bit do_stop);
    logic acked;
    bit   match;
    match = (dev == 7'h3C);
    bus_start();
    put_byte({dev, 1'b0}, acked);
    check_val({tag, "_dack"}, acked, match);
    for (int i = 0; i < n; i++) begin
      put_byte(tx_buf[i], acked);
      check_val($sformatf("%s_ack%0d", tag, i), acked, match);
      if (match) begin
        if (i == 0)      m_ptr[15:8] = tx_buf[i];
        else if (i == 1) m_ptr[7:0]  = tx_buf[i];
        else begin
          exp_q.push_back({m_ptr, tx_buf[i]});
          m_mem[m_ptr[7:0]] = tx_buf[i];
          m_ptr = m_ptr + 16'd1;
        end
      end
    end
    if (do_stop) begin
      check_val({tag, "_busy"}, busy, 1'b1);
      bus_stop();
    end
  endtask

  // Read n bytes from the current pointer, ACK all but the last.
  task automatic txn_read(input string tag, input int n);
    logic       acked;
    logic [7:0] v;
    bus_start();
    put_byte({7'h3C, 1'b1}, acked);
    check_val({tag, "_dack"}, acked, 1'b1);
    for (int i = 0; i < n; i++) begin
      get_byte(v, i < n - 1);
      check_val($sformatf("%s_rd%0d", tag, i), v, m_mem[m_ptr[7:0]]);
      if (i < n - 1) m_ptr = m_ptr + 16'd1;
    end
    check_val({tag, "_oe_nack"}, sda_oe, 1'b0);
    bus_stop();
    check_val({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic set_ptr(input logic [15:0] p);
    tx_buf[0] = p[15:8];
    tx_buf[1] = p[7:0];
  endtask

  initial begin
    logic        acked;
    logic [15:0] p;
    int          n;
    logic [6:0]  bad;

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_oe",    sda_oe,  1'b0);
    check_val("rst_stb",   wr_stb,  1'b0);
    check_val("rst_waddr", wr_addr, 16'h0);
    check_val("rst_wdata", wr_data, 8'h0);
    check_val("rst_busy",  busy,    1'b0);
    rst = 1'b0;
    wait_q(2);

    // Single write 0x3008 <= 0x82
    set_ptr(16'h3008); tx_buf[2] = 8'h82;
    txn_write("w1", 7'h3C, 3, 1'b1);
    check_wr("w1");
    check_val("w1_mem", m_mem[8'h08], 8'h82);

    // Two-phase read of 0x3008
    set_ptr(16'h3008);
    txn_write("p1", 7'h3C, 2, 1'b1);
    txn_read("r1", 1);

    // Wrong device: no ACK, no strobe, SDA never driven
    oe_cnt = 0;
    set_ptr(16'h0005); tx_buf[2] = 8'hAA;
    txn_write("bad", 7'h21, 3, 1'b1);
    check_wr("bad");
    check_val("bad_oe", oe_cnt, 0);

    // Burst crossing 0x00FF
    set_ptr(16'h00FF); tx_buf[2] = 8'h11; tx_buf[3] = 8'h22; tx_buf[4] = 8'h33;
    txn_write("burst", 7'h3C, 5, 1'b1);
    check_wr("burst");

    // Fill 0x10/0x11, then repeated START after the pointer phase
    set_ptr(16'h0010); tx_buf[2] = 8'($urandom); tx_buf[3] = 8'($urandom);
    txn_write("fill", 7'h3C, 4, 1'b1);
    check_wr("fill");
    set_ptr(16'h0010);
    txn_write("sr", 7'h3C, 2, 1'b0);
    txn_read("sr_rd", 2);

    // Reset in the 4th bit of a data byte
    bus_start();
    put_byte(8'h78, acked);
    put_byte(8'h00, acked);
    put_byte(8'h20, acked);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    m_sda = 1'b0; wait_q(1);
    m_scl = 1'b1; wait_q(1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_oe",   sda_oe, 1'b0);
    check_val("mid_rst_busy", busy,   1'b0);
    m_scl = 1'b1; m_sda = 1'b1;
    wait_q(2);
    rst = 1'b0;
    m_ptr = 16'h0000;
    wait_q(2);
    check_val("mid_rst_waddr", wr_addr, 16'h0);
    check_wr("mid_rst");
    set_ptr(16'h0040); tx_buf[2] = 8'h5A; tx_buf[3] = 8'hC3;
    txn_write("post", 7'h3C, 4, 1'b1);
    check_wr("post");
    set_ptr(16'h0040);
    txn_write("post_p", 7'h3C, 2, 1'b1);
    txn_read("post_rd", 2);

    // Randomized write/read-back, including pointer wrap and foreign addresses
    for (int k = 0; k < 6; k++) begin
      p = (k == 0) ? 16'hFFFE : 16'($urandom);
      n = int'($urandom_range(1, 4));
      set_ptr(p);
      for (int i = 0; i < n; i++) tx_buf[2 + i] = 8'($urandom);
      txn_write($sformatf("rw%0d", k), 7'h3C, 2 + n, 1'b1);
      check_wr($sformatf("rw%0d", k));
      bad = 7'($urandom);
      if (bad == 7'h3C) bad = 7'h3D;
      tx_buf[0] = 8'($urandom); tx_buf[1] = 8'($urandom);
      txn_write($sformatf("rb%0d", k), bad, 2, 1'b1);
      set_ptr(p);
      txn_write($sformatf("rp%0d", k), 7'h3C, 2, 1'b1);
      txn_read($sformatf("rr%0d", k), n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_slave_regs.md
Name: sccb_slave_regs

Overview:
- SCCB/I2C responder with a byte-wide register bank. It is the far end of the camera-configuration bus that our IIC master drives from the PLL-derived IIC clock.
- Used in simulation as an OV5640 stand-in, and on-board as an FPGA-side config target.
- Decodes START/STOP, matches a 7-bit device address, takes a 16-bit register pointer, and serves burst writes and reads with auto-increment.
- Oversamples SCL/SDA on the system clock.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit device address that is ACKed.
- MEM_AW, 8, log2 depth of the internal byte register bank; pointer low MEM_AW bits index the bank.
- FILT_LEN, 4, stable-sample count used only when SCCB_SLAVE_GLITCH_FILTER_EN is defined.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- rst  input  1  reset, asynchronous, active-high.
- scl_i  input  1  bus SCL (open-drain, sampled).
- sda_i  input  1  bus SDA (sampled).
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- wr_stb  output  1  one-cycle pulse per accepted data byte.
- wr_addr  output  16  register pointer of the byte written.
- wr_data  output  8  byte written.
- busy  output  1  high from START until STOP or bus release.

Behaviour:
- Input path: scl_i/sda_i pass through 2-FF synchronisers, then an edge detector on the synchronised values.
- Bus events:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - SCL rise = sample point. SCL fall = drive point; sda_oe updates in the cycle after a detected SCL fall.
- Reset values: sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, state=IDLE, pointer=0, bit counter=0. Bank contents are not reset.
- States:
  - IDLE: wait for START.
  - DEVADDR: shift 8 bits MSB-first.
  - ACK_DEV:
    - Address match, R/W=0: drive ACK, go to REG_HI.
    - Address match, R/W=1: drive ACK, go to RD_BYTE.
    - Mismatch: no ACK, go to WAIT_STOP.
  - REG_HI / ACK_HI: receive pointer[15:8], ACK.
  - REG_LO / ACK_LO: receive pointer[7:0], ACK.
  - WR_BYTE / ACK_WR:
    - Receive byte and ACK.
    - wr_stb pulses on the SCL rise of bit 0, with wr_addr=pointer and wr_data=byte.
    - bank[pointer[MEM_AW-1:0]] is written on that same cycle.
    - Pointer increments after the write; return to WR_BYTE.
  - RD_BYTE:
    - Load bank[pointer] at ACK_DEV exit.
    - Drive each bit on SCL fall: sda_oe = ~bit.
    - Release SDA after bit 0.
  - RD_ACK:
    - Sample master ACK on SCL rise.
    - ACK (0): pointer increments, go to RD_BYTE.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: SDA released; ignore bits until START or STOP.
- Event priority:
  - START in any state: abort, busy=1, go to DEVADDR. This covers repeated START; the pointer is kept.
  - STOP in any state: go to IDLE, sda_oe=0, busy=0. A partial byte is discarded with no wr_stb.
- Pointer:
  - 16 bits, wraps 16'hFFFF -> 16'h0000.
  - The bank index aliases modulo 2^MEM_AW.
  - A read following a write-address phase plus STOP/Sr reads from the set pointer (SCCB two-phase read).
- Write with only REG_HI received then STOP: pointer[15:8] is updated, pointer[7:0] is unchanged, no wr_stb.
- ACK timing: sda_oe=1 from the SCL fall after bit 0 until the next SCL fall.
- Simultaneous SCL and SDA change in one sample: treated as a data change, not START/STOP.
- rst asserted mid-transfer: immediate release (sda_oe=0) and return to IDLE. The next transaction must begin with START.

Optional Feature:
- Macro: SCCB_SLAVE_GLITCH_FILTER_EN.
- Defined: each synchronised line feeds a filter that updates its output only after FILT_LEN consecutive identical samples. Pulses shorter than FILT_LEN clk are suppressed; event detection latency grows by FILT_LEN cycles.
- Undefined: the synchroniser output is used directly, with 2-cycle latency.

Test Plan:
- Write 0x78 (addr 0x3C, W), 0x30, 0x08, 0x82, STOP:
  - ACK on all 4 bytes.
  - One wr_stb with wr_addr=0x3008, wr_data=0x82.
  - bank[0x08]=0x82.
- Write pointer 0x3008, STOP, then START 0x79, read 1 byte, master NACK, STOP:
  - SDA carries 0x82.
  - sda_oe=0 after the NACK.
  - busy=0 after STOP.
- Address 0x42 (W): no ACK (sda_oe stays 0); further bytes ignored; no wr_stb.
- Burst write pointer 0x00FF, data 0x11, 0x22, 0x33:
  - wr_addr sequence 0x00FF, 0x0100, 0x0101.
  - bank[0xFF]=0x11, bank[0x00]=0x22, bank[0x01]=0x33.
- Repeated START after REG_LO (pointer 0x0010), then 0x79, read 2 bytes with ACK then NACK: returns bank[0x10], bank[0x11].
- rst pulsed during the 4th bit of a data byte: sda_oe=0 and busy=0 immediately; no wr_stb; next full write completes normally.
